bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Shares the core's single AXI4-Lite master port between NREQ simple requesters (requester 0 = instruction fetch, requester 1 = load/store unit). It grants one request at a time, sequences the AXI4-Lite read or write channels for it, and returns a one-cycle response pulse to the granted requester. One transaction is outstanding at any time.

## Interface
- NREQ, default 2, number of requesters (at least 2).
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request; held until the matching req_ready.
- req_ready  out  NREQ  one-hot accept pulse, one cycle.
- req_write  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ×32  byte address.
- req_wdata  in  NREQ×32  write data.
- req_wstrb  in  NREQ×4  write byte strobes.
- rsp_valid  out  NREQ  one-hot response pulse, one cycle; no backpressure.
- rsp_rdata  out  32  read data, valid with rsp_valid.
- rsp_err  out  1  1 when the AXI resp is nonzero.
- awvalid  out  1  write-address valid.
- awready  in  1  write-address ready.
- awaddress  out  32  write address.
- awprot  out  3  write protection.
- wvalid  out  1  write-data valid.
- wready  in  1  write-data ready.
- wdata  out  32  write data.
- wstrb  out  4  write strobes.
- bvalid  in  1  write-response valid.
- bready  out  1  write-response ready.
- bresp  in  2  write response.
- arvalid  out  1  read-address valid.
- arready  in  1  read-address ready.
- araddress  out  32  read address.
- arprot  out  3  read protection.
- rvalid  in  1  read-data valid.
- rready  out  1  read-data ready.
- rdata  in  32  read data.
- rresp  in  2  read response.

## Operation
- FSM states:
  - IDLE. If any req_valid is high, pick the winner, pulse its req_ready, and capture write, addr, wdata, wstrb and the grant index. Go to AR (read) or AW (write).
  - AR. Hold arvalid. On arready, go to R.
  - R. Hold rready. On rvalid, register rsp_valid[grant], rsp_rdata = rdata, rsp_err = (rresp != 0). Go to IDLE.
  - AW. Hold awvalid and wvalid. Each valid drops independently after its own handshake. When both handshakes are done (same cycle or different cycles), go to B.
  - B. Hold bready. On bvalid, register rsp_valid[grant] with rsp_err = (bresp != 0) and rsp_rdata = 0. Go to IDLE.
- awprot and arprot: 3'b100 when grant = 0 (instruction access), 3'b000 otherwise.
- Address and data outputs come from the captured registers and are stable while the corresponding valid is high.
- A request arriving outside IDLE waits. req_ready stays 0 outside IDLE.

## Timing
- Reset values (asynchronous):
  - state = IDLE.
  - All valid, ready and rsp outputs = 0.
  - Address, data and strobe outputs = 0.
  - Round-robin pointer = 0.
- Read, zero-wait slave:
  - cycle T: req_ready pulses.
  - T+1: arvalid high, arready handshake.
  - T+2: rready high, rvalid handshake.
  - T+3: rsp_valid high.
- Write, zero-wait slave: accept at T, aw and w handshakes at T+1, b handshake at T+2, rsp_valid at T+3.
- rsp_valid coincides with IDLE, so a new request can be accepted in the same cycle. Back-to-back issue rate is 1 transaction per 3 cycles.
- Reset asserted mid-transaction aborts it immediately with no response. The downstream slave shares the same reset.

## Configuration
- ARB_ROUND_ROBIN_EN defined: round-robin arbitration. Search starts at the pointer; after each grant, pointer = grant+1 modulo NREQ.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, lowest index wins. Fetch (requester 0) beats load/store.

## Structure
- Package bus_pkg holds:
  - the state enum;
  - PROT_INSN = 3'b100 and PROT_DATA = 3'b000;
  - AXI resp codes OKAY, EXOKAY, SLVERR, DECERR.
- Sub-module rr_pick: combinational one-hot winner from a request vector and a pointer. The macro selects whether the pointer is used or tied to 0.

## Test plan
- Single read, requester 1, addr 0x100, rdata 0xDEADBEEF, zero-wait slave -> rsp_valid[1] at accept+3, rsp_rdata 0xDEADBEEF, rsp_err 0, arprot 0.
- Write from requester 1, addr 0x40, wdata 0x12345678, wstrb 4'b0011; slave delays wready 3 cycles after awready -> awvalid drops after 1 cycle, wvalid held 4 cycles, one bready handshake, rsp_valid[1] with rsp_err 0.
- Both requesters held valid for 4 transactions -> with the macro, grants alternate 0,1,0,1; without it, grants are 0,0,0,0 until requester 0 drops.
- Read returning rresp = 2'b10 -> rsp_err 1 and rdata passed through; write returning bresp = 2'b11 -> rsp_err 1.
- Reset pulled low while in R -> all outputs 0 in the same cycle, no rsp_valid; after release, first grant goes to requester 0.
- Fetch read from requester 0 -> arprot 3'b100; req_ready never asserts outside IDLE.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: arbiter state encoding, AXI protection values and AXI response codes.
package bus_pkg;
  typedef enum logic [2:0] {IDLE, AR, R, AW, B} state_t;
  localparam logic [2:0] PROT_INSN = 3'b100;
  localparam logic [2:0] PROT_DATA = 3'b000;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// rr_pick: combinational one-hot winner, searching upward from ptr with wraparound.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx
);
  // descending scan with last-hit-wins leaves the smallest offset from ptr as winner
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % NREQ]) begin
        idx = PW'((int'(ptr) + i) % NREQ);
        gnt = NREQ'(1) << idx;
      end
    end
  end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one AXI4-Lite master port among NREQ requesters, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest index wins.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_write,
  input  logic [NREQ-1:0][31:0] req_addr,
  input  logic [NREQ-1:0][31:0] req_wdata,
  input  logic [NREQ-1:0][3:0] req_wstrb,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic                 awvalid,
  input  logic                 awready,
  output logic [31:0]          awaddress,
  output logic [2:0]           awprot,
  output logic                 wvalid,
  input  logic                 wready,
  output logic [31:0]          wdata,
  output logic [3:0]           wstrb,
  input  logic                 bvalid,
  output logic                 bready,
  input  logic [1:0]           bresp,
  output logic                 arvalid,
  input  logic                 arready,
  output logic [31:0]          araddress,
  output logic [2:0]           arprot,
  input  logic                 rvalid,
  output logic                 rready,
  input  logic [31:0]          rdata,
  input  logic [1:0]           rresp
);
  localparam int PW = $clog2(NREQ);
  state_t state, nxt;
  logic [PW-1:0] gidx, pick_idx, ptr;
  logic [NREQ-1:0] pick;
  logic [31:0] addr_q, wdata_q;
  logic [3:0] wstrb_q;
  logic aw_done, w_done, accept, aw_fin, w_fin;
  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req(req_valid),
    .ptr(ptr),
    .gnt(pick),
    .idx(pick_idx)
  );
`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr <= '0;
    else if (accept) ptr <= (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
  end
`else
  assign ptr = '0;
`endif
  assign accept = state == IDLE && |req_valid;
  // gated by reset so a held request cannot show a ready pulse while in reset
  assign req_ready = (accept && reset) ? pick : '0;
  assign aw_fin = aw_done || awready;
  assign w_fin = w_done || wready;
  assign awvalid = state == AW && !aw_done;
  assign wvalid = state == AW && !w_done;
  assign bready = state == B;
  assign arvalid = state == AR;
  assign rready = state == R;
  assign awaddress = addr_q;
  assign araddress = addr_q;
  assign wdata = wdata_q;
  assign wstrb = wstrb_q;
  assign arprot = (arvalid && gidx == '0) ? PROT_INSN : PROT_DATA;
  assign awprot = (awvalid && gidx == '0) ? PROT_INSN : PROT_DATA;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (|req_valid) nxt = req_write[pick_idx] ? AW : AR;
      AR:      if (arready) nxt = R;
      R:       if (rvalid) nxt = IDLE;
      AW:      if (aw_fin && w_fin) nxt = B;
      B:       if (bvalid) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      gidx      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= nxt;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      if (accept) begin
        gidx    <= pick_idx;
        addr_q  <= req_addr[pick_idx];
        wdata_q <= req_wdata[pick_idx];
        wstrb_q <= req_wstrb[pick_idx];
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (state == AW) begin
        aw_done <= aw_fin;
        w_done  <= w_fin;
      end
      if (state == R && rvalid) begin
        rsp_valid <= NREQ'(1) << gidx;
        rsp_rdata <= rdata;
        rsp_err   <= rresp != OKAY;
      end
      if (state == B && bvalid) begin
        rsp_valid <= NREQ'(1) << gidx;
        rsp_rdata <= '0;
        rsp_err   <= bresp != OKAY;
      end
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: scoreboard bench for bus_arbiter with an AXI4-Lite slave model and random traffic.
module tb_bus_arbiter;
  localparam int NREQ = 2;
  logic clk = 1'b0, reset = 1'b1;
  logic [NREQ-1:0] req_valid = '0, req_write = '0, req_ready, rsp_valid;
  logic [NREQ-1:0][31:0] req_addr = '0, req_wdata = '0;
  logic [NREQ-1:0][3:0] req_wstrb = '0;
  logic [31:0] rsp_rdata, awaddress, wdata, araddress;
  logic rsp_err, awvalid, wvalid, bready, arvalid, rready;
  logic [2:0] awprot, arprot;
  logic [3:0] wstrb;
  logic awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;
  logic [1:0] bresp = 0, rresp = 0;
  logic [31:0] rdata = 0;

  bus_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .awvalid(awvalid), .awready(awready), .awaddress(awaddress), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddress(araddress), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  always #5 clk = ~clk;

  typedef struct {logic wr; logic [31:0] addr, wdata; logic [3:0] strb;} txn_t;
  typedef struct {int idx; logic wr; logic [31:0] addr, wdata, rdata; logic [3:0] strb; logic err; int acc;} exp_t;

  txn_t pend[NREQ][$];
  exp_t sb[$];
  exp_t cur;
  int glog[$];
  logic [31:0] smem[int];
  logic [31:0] mmem[int];
  int total = 0, bad = 0, cyc = 0, mode = 0, maxgap = 0, mptr = 0;
  int awn, wn, bn;
  bit busy = 0;
  logic [NREQ-1:0] last_oh;
  logic [31:0] last_rdata;
  logic last_err;
  logic [2:0] last_arprot;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_valids"}, {awvalid, wvalid, bready, arvalid, rready}, 0);
    chk({tag, "_awaddress"}, awaddress, 0);
    chk({tag, "_araddress"}, araddress, 0);
    chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_wstrb"}, wstrb, 0);
    chk({tag, "_prot"}, {awprot, arprot}, 0);
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) old[b*8 +: 8] = d[b*8 +: 8];
    return old;
  endfunction

  // who should win: round-robin from the pointer, or plain lowest index
  function automatic int winner(input logic [NREQ-1:0] v, input int p);
    int base = p;
`ifndef ARB_ROUND_ROBIN_EN
    base = 0;
`endif
    for (int k = 0; k < NREQ; k++) if (v[(base + k) % NREQ]) return (base + k) % NREQ;
    return -1;
  endfunction

  task automatic push(input int r, input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    txn_t t;
    t.wr = wr; t.addr = a; t.wdata = d; t.strb = s;
    pend[r].push_back(t);
  endtask

  // requester drivers: hold each request until its ready pulse, then optional idle gap
  initial begin
    bit acc[NREQ];
    int gap[NREQ];
    for (int r = 0; r < NREQ; r++) gap[r] = 0;
    forever begin
      @(negedge clk);
      for (int r = 0; r < NREQ; r++) acc[r] = req_ready[r];
      @(posedge clk);
      #1;
      for (int r = 0; r < NREQ; r++) begin
        if (acc[r] && pend[r].size() > 0) begin
          void'(pend[r].pop_front());
          gap[r] = maxgap > 0 ? $urandom_range(0, maxgap) : 0;
        end
        if (gap[r] > 0) begin
          gap[r]--;
          req_valid[r] = 1'b0;
        end else if (pend[r].size() > 0) begin
          req_valid[r] = 1'b1;
          req_write[r] = pend[r][0].wr;
          req_addr[r] = pend[r][0].addr;
          req_wdata[r] = pend[r][0].wdata;
          req_wstrb[r] = pend[r][0].strb;
        end else req_valid[r] = 1'b0;
      end
    end
  end

  // AXI4-Lite slave: mode 0 zero-wait, 1 random stalls, 2 wready 3 cycles after aw, 3 no read data
  initial begin
    bit rd_p = 0, aw_g = 0, w_g = 0, b_p = 0;
    logic [31:0] ra = 0, wa = 0, wd = 0;
    logic [3:0] ws = 0;
    int rdly = 0, bdly = 0, wcnt = 0;
    forever begin
      @(negedge clk);
      if (arvalid && arready) begin rd_p = 1; ra = araddress; rdly = mode == 1 ? $urandom_range(0, 3) : 0; end
      if (rvalid && rready) rd_p = 0;
      if (awvalid && awready) begin aw_g = 1; wa = awaddress; wcnt = 0; end
      if (wvalid && wready) begin w_g = 1; wd = wdata; ws = wstrb; end
      if (bvalid && bready) b_p = 0;
      @(posedge clk);
      #1;
      if (!reset) begin
        rd_p = 0; aw_g = 0; w_g = 0; b_p = 0;
        {arready, awready, wready, rvalid, bvalid} = '0;
        continue;
      end
      if (aw_g && w_g) begin
        if (!wa[12]) smem[int'(wa)] = merge(smem.exists(int'(wa)) ? smem[int'(wa)] : dflt(wa), wd, ws);
        b_p = 1; bresp = wa[12] ? 2'b11 : 2'b00;
        bdly = mode == 1 ? $urandom_range(0, 3) : 0;
        aw_g = 0; w_g = 0;
      end
      wcnt++;
      arready = mode == 1 ? 1'($urandom_range(0, 1)) : 1'b1;
      awready = mode == 1 ? 1'($urandom_range(0, 1)) : 1'b1;
      wready = mode == 1 ? 1'($urandom_range(0, 1)) : mode == 2 ? (aw_g && wcnt >= 3) : 1'b1;
      rvalid = rd_p && rdly == 0 && mode != 3;
      rdata = rvalid ? (smem.exists(int'(ra)) ? smem[int'(ra)] : dflt(ra)) : 32'h0;
      rresp = (rvalid && ra[12]) ? 2'b10 : 2'b00;
      if (rd_p && rdly > 0) rdly--;
      bvalid = b_p && bdly == 0;
      if (b_p && bdly > 0) bdly--;
    end
  end

  // monitor: checks accepts against the arbitration model and pops the scoreboard on responses
  initial begin
    exp_t e;
    int w;
    logic [NREQ-1:0] er;
    logic [31:0] old;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("rst_quiet", {req_ready, rsp_valid}, 0);
        continue;
      end
      if (|rsp_valid) begin
        if (sb.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
        else begin
          e = sb.pop_front();
          chk("rsp_onehot", rsp_valid, NREQ'(1) << e.idx);
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", rsp_err, e.err);
          if (mode == 0) chk("rsp_latency", cyc - e.acc, 3);
          last_oh = rsp_valid; last_rdata = rsp_rdata; last_err = rsp_err;
          busy = 0;
        end
      end
      if (!busy) chk("idle_quiet", {awvalid, wvalid, bready, arvalid, rready}, 0);
      if (busy && arvalid && arready) begin
        chk("ar_op", 1'b0, cur.wr);
        chk("ar_addr", araddress, cur.addr);
        chk("arprot", arprot, cur.idx == 0 ? 3'b100 : 3'b000);
        last_arprot = arprot;
      end
      if (busy && awvalid && awready) begin
        chk("aw_op", 1'b1, cur.wr);
        chk("aw_addr", awaddress, cur.addr);
        chk("awprot", awprot, cur.idx == 0 ? 3'b100 : 3'b000);
      end
      if (busy && wvalid && wready) begin
        chk("w_data", wdata, cur.wdata);
        chk("w_strb", wstrb, cur.strb);
      end
      w = busy ? -1 : winner(req_valid, mptr);
      er = w < 0 ? '0 : NREQ'(1) << w;
      chk("req_ready", req_ready, er);
      if (w >= 0 && pend[w].size() > 0) begin
        e.idx = w; e.wr = pend[w][0].wr; e.addr = pend[w][0].addr;
        e.wdata = pend[w][0].wdata; e.strb = pend[w][0].strb;
        e.err = e.addr[12]; e.acc = cyc;
        old = mmem.exists(int'(e.addr)) ? mmem[int'(e.addr)] : dflt(e.addr);
        e.rdata = e.wr ? 32'h0 : old;
        if (e.wr && !e.err) mmem[int'(e.addr)] = merge(old, e.wdata, e.strb);
        sb.push_back(e);
        cur = e; busy = 1;
        glog.push_back(w);
        mptr = (w + 1) % NREQ;
      end
    end
  end

  task automatic drain(input int budget);
    int n = 0;
    awn = 0; wn = 0; bn = 0;
    do begin
      @(negedge clk);
      #1;
      awn += int'(awvalid); wn += int'(wvalid); bn += int'(bvalid && bready);
      n++;
    end while ((busy || sb.size() > 0 || pend[0].size() > 0 || pend[1].size() > 0) && n < budget);
    chk("drain_outstanding", sb.size() + pend[0].size() + pend[1].size(), 0);
  endtask

  initial begin
    int seq[4];
    int n;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2 chk_quiet("reset");
    @(negedge clk);
    #2 reset = 1'b1;

    smem[32'h100] = 32'hDEADBEEF;
    mmem[32'h100] = 32'hDEADBEEF;
    push(1, 1'b0, 32'h100, 32'h0, 4'h0);
    drain(200);
    chk("t1_rdata", last_rdata, 32'hDEADBEEF);
    chk("t1_err", last_err, 0);
    chk("t1_onehot", last_oh, 2'b10);
    chk("t1_arprot", last_arprot, 3'b000);

    mode = 2;
    push(1, 1'b1, 32'h40, 32'h12345678, 4'b0011);
    drain(200);
    chk("t2_aw_cycles", awn, 1);
    chk("t2_w_cycles", wn, 4);
    chk("t2_b_handshakes", bn, 1);
    chk("t2_onehot", last_oh, 2'b10);
    chk("t2_err", last_err, 0);

    mode = 0;
    glog.delete();
    for (int i = 0; i < 4; i++) begin
      push(0, 1'b0, 32'(i * 8), 32'h0, 4'h0);
      push(1, 1'b0, 32'(i * 8 + 4), 32'h0, 4'h0);
    end
    drain(400);
`ifdef ARB_ROUND_ROBIN_EN
    seq = '{0, 1, 0, 1};
`else
    seq = '{0, 0, 0, 0};
`endif
    for (int i = 0; i < 4; i++) chk($sformatf("t3_grant%0d", i), glog.size() > i ? glog[i] : -1, seq[i]);

    push(0, 1'b0, 32'h1108, 32'h0, 4'h0);
    drain(200);
    chk("t4_rd_err", last_err, 1);
    chk("t4_rd_data", last_rdata, dflt(32'h1108));
    push(1, 1'b1, 32'h1040, 32'hCAFEF00D, 4'hF);
    drain(200);
    chk("t4_wr_err", last_err, 1);
    chk("t4_wr_rdata", last_rdata, 0);

    push(0, 1'b0, 32'h20, 32'h0, 4'h0);
    drain(200);
    chk("t5_arprot", last_arprot, 3'b100);
    chk("t5_onehot", last_oh, 2'b01);

    mode = 3;
    push(0, 1'b0, 32'h80, 32'h0, 4'h0);
    n = 0;
    while (!rready && n < 50) begin @(negedge clk); n++; end
    chk("t6_in_r", rready, 1);
    #2 reset = 1'b0;
    #1 chk_quiet("t6");
    sb.delete(); busy = 0; mptr = 0;
    for (int r = 0; r < NREQ; r++) pend[r].delete();
    repeat (3) @(negedge clk);
    mode = 0;
    #2 reset = 1'b1;
    glog.delete();
    push(0, 1'b0, 32'h10, 32'h0, 4'h0);
    push(1, 1'b0, 32'h14, 32'h0, 4'h0);
    drain(200);
    chk("t6_first_grant", glog.size() > 0 ? glog[0] : -1, 0);

    mode = 1;
    maxgap = 3;
    for (int r = 0; r < NREQ; r++)
      for (int i = 0; i < 30; i++)
        push(r, 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 15) << 2) | (($urandom_range(0, 7) == 0) ? 32'h1000 : 32'h0),
             $urandom, 4'($urandom_range(0, 15)));
    drain(20000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
